// File: rtl/bist_march_sequencer.sv
// Address/operation sequencer for the SRAM BIST controller: walks every address of
// every march element (up or down), several ops per address, once per data background.
module bist_march_sequencer #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned ELEM_WIDTH = 3,
    parameter int unsigned OPS_WIDTH  = 2,
    parameter int unsigned BG_WIDTH   = 2,
    parameter int unsigned NUM_BG     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  cen,
    input  logic                  elem_dir,
    input  logic [OPS_WIDTH-1:0]  elem_ops_m1,
    input  logic                  elem_last,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [OPS_WIDTH-1:0]  op_idx,
    output logic [ELEM_WIDTH-1:0] elem_idx,
    output logic [BG_WIDTH-1:0]   bg_idx,
    output logic                  valid,
    output logic                  elem_end,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONES = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
    localparam logic [BG_WIDTH-1:0]   BG_LAST   = BG_WIDTH'(NUM_BG - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [OPS_WIDTH-1:0]  op_idx_q, op_idx_d;
    logic [ELEM_WIDTH-1:0] elem_idx_q, elem_idx_d;
    logic [BG_WIDTH-1:0]   bg_idx_q, bg_idx_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH-1:0] term;
    logic                  last_op;
    logic                  at_term;

    // The terminal address is where the current walk direction ends.
    assign term    = elem_dir ? ADDR_ZERO : ADDR_ONES;
    assign last_op = (op_idx_q == elem_ops_m1);
    assign at_term = (addr_q == term);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            op_idx_q   <= '0;
            elem_idx_q <= '0;
            bg_idx_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            op_idx_q   <= op_idx_d;
            elem_idx_q <= elem_idx_d;
            bg_idx_q   <= bg_idx_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        op_idx_d   = op_idx_q;
        elem_idx_d = elem_idx_q;
        bg_idx_d   = bg_idx_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    elem_idx_d = '0;
                    bg_idx_d   = '0;
                end
            end
            // One cycle for the element ROM to present the new element's direction.
            S_LOAD: begin
                addr_d   = elem_dir ? ADDR_ONES : ADDR_ZERO;
                op_idx_d = '0;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (cen) begin
                    if (!last_op) begin
                        op_idx_d = op_idx_q + OPS_WIDTH'(1);
                    end else begin
                        op_idx_d = '0;
                        if (!at_term) begin
                            addr_d = elem_dir ? (addr_q - ADDR_WIDTH'(1))
                                              : (addr_q + ADDR_WIDTH'(1));
                        end else if (!elem_last) begin
                            elem_idx_d = elem_idx_q + ELEM_WIDTH'(1);
                            state_d    = S_LOAD;
                        end else if (bg_idx_q != BG_LAST) begin
                            bg_idx_d   = bg_idx_q + BG_WIDTH'(1);
                            elem_idx_d = '0;
                            state_d    = S_LOAD;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort freezes the indices where they are and suppresses completion.
        if (abort) begin
            state_d    = S_IDLE;
            addr_d     = addr_q;
            op_idx_d   = op_idx_q;
            elem_idx_d = elem_idx_q;
            bg_idx_d   = bg_idx_q;
            done_d     = 1'b0;
        end
    end

    always_comb begin
        valid    = (state_q == S_RUN);
        busy     = (state_q != S_IDLE);
        elem_end = (state_q == S_RUN) & cen & last_op & at_term;
        addr     = addr_q;
        op_idx   = op_idx_q;
        elem_idx = elem_idx_q;
        bg_idx   = bg_idx_q;
        done     = done_q;
    end

endmodule
